// File: rtl/common_pkg.sv
// Shared bus widths plus the Wishbone initiator's state type and default burst width.
package common_pkg;

    localparam int WB_ADDR_WIDTH = 10;
    localparam int DATA_WIDTH    = 8;

    localparam int WB_INITIATOR_BURST_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } wb_initiator_state_t;

endpackage : common_pkg

// File: rtl/wb_initiator.sv
// Wishbone classic initiator: runs one single/burst read or write command as
// a sequence of STB/ACK transfers with a one-cycle STB-low gap between words.
// Every output is registered; wb_ack_i never reaches an output combinationally.
// Optional per-transfer ACK timeout: define WB_INITIATOR_TIMEOUT_EN.
module wb_initiator
    import common_pkg::*;
#(
    parameter int BURST_WIDTH    = WB_INITIATOR_BURST_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_n_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]    cmd_data_i,
    input  logic [BURST_WIDTH-1:0]   cmd_count_i,
    output logic                     rsp_valid_o,
    output logic [DATA_WIDTH-1:0]    rsp_data_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    input  logic [DATA_WIDTH-1:0]    wb_data_i,
    output logic                     wb_we_o,
    output logic                     wb_cycle_o,
    output logic                     wb_strobe_o,
    input  logic                     wb_ack_i
);

    // One extra bit so a zero count can hold the full 2**BURST_WIDTH words.
    localparam int REM_W = BURST_WIDTH + 1;

    wb_initiator_state_t      state_q, state_d;
    logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     we_q, we_d;
    logic [REM_W-1:0]         remaining_q, remaining_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     cyc_q, cyc_d;
    logic                     stb_q, stb_d;
    logic                     tmo_hit;

`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Count stalled STROBE cycles; any other cycle (including ack) restarts the count.
    always_comb begin
        tmo_d = '0;
        if (state_q == STROBE && !wb_ack_i) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
    end

    // Timeout counter register.
    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    // Abort on the edge that would complete the TIMEOUT_CYCLES-th stalled STROBE cycle.
    assign tmo_hit = (state_q == STROBE) && !wb_ack_i &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout the initiator waits for ack forever.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign tmo_hit        = 1'b0;
`endif

    // Next-state and next-output logic for the command/transfer sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        remaining_d = remaining_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        done_d      = 1'b0;
        err_d       = err_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;

        case (state_q)
            IDLE: begin
                // Ready rises one cycle after done_o because we arrive here with it low.
                cmd_ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_q) begin
                    addr_d      = cmd_addr_i;
                    wdata_d     = cmd_data_i;
                    we_d        = cmd_we_i;
                    remaining_d = (cmd_count_i == '0) ? {1'b1, {BURST_WIDTH{1'b0}}}
                                                      : {1'b0, cmd_count_i};
                    cmd_ready_d = 1'b0;
                    err_d       = 1'b0;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    state_d     = STROBE;
                end
            end

            STROBE: begin
                if (wb_ack_i) begin
                    if (!we_q) begin
                        rsp_data_d = wb_data_i;
                    end
                    rsp_valid_d = 1'b1;
                    remaining_d = remaining_q - REM_W'(1);
                    addr_d      = addr_q + WB_ADDR_WIDTH'(1);
                    stb_d       = 1'b0;
                    if (remaining_q == REM_W'(1)) begin
                        cyc_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end else if (tmo_hit) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end

            GAP: begin
                // CYC stays high through the gap; STB returns with the next address.
                stb_d   = 1'b1;
                state_d = STROBE;
            end

            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and all registered outputs; reset releases the bus immediately.
    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            remaining_q <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            remaining_q <= remaining_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign wb_addr_o   = addr_q;
    assign wb_data_o   = wdata_q;
    assign wb_we_o     = we_q;
    assign wb_cycle_o  = cyc_q;
    assign wb_strobe_o = stb_q;

endmodule : wb_initiator

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: a 1-cycle-ack RAM responder, a command-level model
// (expected transfer queue and reference memory) checked every cycle, and
// directed tests with literal expectations.
module tb_wb_initiator;
    import common_pkg::*;

    localparam int BW = 8;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     cmd_valid = 1'b0;
    logic                     cmd_ready;
    logic                     cmd_we = 1'b0;
    logic [WB_ADDR_WIDTH-1:0] cmd_addr = '0;
    logic [DATA_WIDTH-1:0]    cmd_data = '0;
    logic [BW-1:0]            cmd_count = '0;
    logic                     rsp_valid;
    logic [DATA_WIDTH-1:0]    rsp_data;
    logic                     done;
    logic                     err;
    logic [WB_ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0]    wb_wdata;
    logic [DATA_WIDTH-1:0]    wb_rdata;
    logic                     wb_we;
    logic                     wb_cyc;
    logic                     wb_stb;
    logic                     wb_ack;

    always #5 clk = ~clk;

    wb_initiator #(.BURST_WIDTH(BW), .TIMEOUT_CYCLES(8)) dut (
        .wb_clock_i  (clk),
        .wb_reset_n_i(rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_addr_i  (cmd_addr),
        .cmd_data_i  (cmd_data),
        .cmd_count_i (cmd_count),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .done_o      (done),
        .err_o       (err),
        .wb_addr_o   (wb_addr),
        .wb_data_o   (wb_wdata),
        .wb_data_i   (wb_rdata),
        .wb_we_o     (wb_we),
        .wb_cycle_o  (wb_cyc),
        .wb_strobe_o (wb_stb),
        .wb_ack_i    (wb_ack)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Responder: RAM with registered ack/read data, one ack per strobe.
    logic [DATA_WIDTH-1:0] mem [0:1023];
    bit ack_gate = 1'b1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_rdata <= '0;
        end else if (ack_gate && wb_cyc && wb_stb && !wb_ack) begin
            wb_ack <= 1'b1;
            if (wb_we) mem[wb_addr] <= wb_wdata;
            else       wb_rdata     <= mem[wb_addr];
        end else begin
            wb_ack <= 1'b0;
        end
    end

    // Command-level model: expected transfers in order, and expected memory.
    typedef struct {
        int addr;
        bit we;
        int wdata;
        int rdata;
    } xfer_t;

    xfer_t exp_q[$];
    int    ref_mem[1024];
    int    exp_rsp_data = 0;
    bit    pend = 1'b0;
    xfer_t pend_x;
    int    obs_addr[$];

    task automatic model_push(input bit we, input int addr, input int data, input int cnt);
        int n;
        n = (cnt == 0) ? (1 << BW) : cnt;
        for (int i = 0; i < n; i++) begin
            xfer_t x;
            x.addr  = (addr + i) % 1024;
            x.we    = we;
            x.wdata = data;
            x.rdata = we ? 0 : ref_mem[x.addr];
            if (we) ref_mem[x.addr] = data;
            exp_q.push_back(x);
        end
    endtask

    // Per-cycle compare: completed transfers match the model, rsp follows each ack by one cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            pend = 1'b0;
            exp_rsp_data = 0;
        end else begin
            chk_eq("rsp_valid", int'(rsp_valid), int'(pend));
            if (pend && rsp_valid) begin
                if (!pend_x.we) exp_rsp_data = pend_x.rdata;
                chk_eq("rsp_data", int'(rsp_data), exp_rsp_data);
            end
            pend = 1'b0;
            if (wb_stb) chk_eq("cyc_with_stb", int'(wb_cyc), 1);
            if (wb_stb && wb_ack) begin
                if (exp_q.size() == 0) begin
                    chk_eq("unexpected_xfer", 1, 0);
                end else begin
                    pend_x = exp_q.pop_front();
                    pend   = 1'b1;
                    obs_addr.push_back(int'(wb_addr));
                    chk_eq("xfer_addr", int'(wb_addr), pend_x.addr);
                    chk_eq("xfer_we", int'(wb_we), int'(pend_x.we));
                    if (pend_x.we) chk_eq("xfer_wdata", int'(wb_wdata), pend_x.wdata);
                end
            end
        end
    end

    task automatic present(input bit we, input int addr, input int data, input int cnt);
        @(posedge clk);
        #1;
        cmd_we    = we;
        cmd_addr  = WB_ADDR_WIDTH'(addr);
        cmd_data  = DATA_WIDTH'(data);
        cmd_count = BW'(cnt);
        cmd_valid = 1'b1;
    endtask

    // Wait for the accepting edge; returns how many windows it took.
    task automatic wait_accept(output int waited);
        bit got;
        got = 1'b0;
        waited = -1;
        for (int n = 1; n <= 3000 && !got; n++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) begin
                @(posedge clk);
                model_push(cmd_we, int'(cmd_addr), int'(cmd_data), int'(cmd_count));
                waited = n;
                got = 1'b1;
            end
        end
        if (!got) chk_eq("accept_timeout", 0, 1);
    endtask

    // Observe windows after accept until done_o; collects timing statistics.
    task automatic track(input int limit, output int dw, output int rc, output int gp, output int sw);
        int rdy;
        bit fin;
        rdy = 0; fin = 1'b0;
        dw = -1; rc = 0; gp = 0; sw = 0;
        for (int k = 1; k <= limit && !fin; k++) begin
            @(negedge clk);
            if (rsp_valid)         rc++;
            if (wb_cyc && !wb_stb) gp++;
            if (wb_stb)            sw++;
            if (cmd_ready)         rdy++;
            if (done) begin
                dw  = k;
                fin = 1'b1;
            end
        end
        chk_eq("ready_low_while_busy", rdy, 0);
        if (!fin) chk_eq("done_timeout", 0, 1);
    endtask

    task automatic run(input bit we, input int addr, input int data, input int cnt,
                       output int dw, output int rc, output int gp, output int sw);
        int w;
        present(we, addr, data, cnt);
        wait_accept(w);
        #1 cmd_valid = 1'b0;
        track(2000, dw, rc, gp, sw);
        @(negedge clk);
        chk_eq("ready_after_done", int'(cmd_ready), 1);
    endtask

    initial begin
        int dw, rc, gp, sw, w;
`ifndef WB_INITIATOR_TIMEOUT_EN
        int done_seen;
`endif
        // Reset state.
        #12;
        chk_eq("rst_ready", int'(cmd_ready), 1);
        chk_eq("rst_cyc", int'(wb_cyc), 0);
        chk_eq("rst_stb", int'(wb_stb), 0);
        chk_eq("rst_done", int'(done), 0);
        chk_eq("rst_err", int'(err), 0);
        chk_eq("rst_rsp_data", int'(rsp_data), 0);
        chk_eq("rst_addr", int'(wb_addr), 0);
        #10 rst_n = 1'b1;

        // Single write then read back.
        run(1'b1, 'h000, 'h55, 1, dw, rc, gp, sw);
        $display("single write 0x000=0x55: done_win=%0d rsp=%0d", dw, rc);
        chk_eq("w1_done_win", dw, 3);
        chk_eq("w1_rsp_cnt", rc, 1);
        run(1'b0, 'h000, 'h00, 1, dw, rc, gp, sw);
        $display("single read 0x000: data=0x%0h done_win=%0d", rsp_data, dw);
        chk_eq("r1_data", int'(rsp_data), 'h55);
        chk_eq("r1_err", int'(err), 0);
        chk_eq("r1_done_win", dw, 3);

        // Fill burst and read back.
        run(1'b1, 'h010, 'hA5, 4, dw, rc, gp, sw);
        $display("fill write 0x010 x4: done_win=%0d gaps=%0d stb=%0d", dw, gp, sw);
        chk_eq("fill_done_win", dw, 12);
        chk_eq("fill_gaps", gp, 3);
        chk_eq("fill_stb_cycles", sw, 8);
        chk_eq("fill_rsp_cnt", rc, 4);
        run(1'b0, 'h010, 'h00, 4, dw, rc, gp, sw);
        $display("burst read 0x010 x4: data=0x%0h rsp=%0d done_win=%0d", rsp_data, rc, dw);
        chk_eq("rd4_rsp_cnt", rc, 4);
        chk_eq("rd4_data", int'(rsp_data), 'hA5);
        chk_eq("rd4_done_win", dw, 12);

        // Address wrap.
        obs_addr.delete();
        run(1'b1, 'h3FE, 'h3C, 4, dw, rc, gp, sw);
        $display("wrap write 0x3FE x4: addrs %0h %0h %0h %0h", obs_addr[0], obs_addr[1], obs_addr[2], obs_addr[3]);
        chk_eq("wrap_n", obs_addr.size(), 4);
        chk_eq("wrap_a0", obs_addr[0], 'h3FE);
        chk_eq("wrap_a1", obs_addr[1], 'h3FF);
        chk_eq("wrap_a2", obs_addr[2], 'h000);
        chk_eq("wrap_a3", obs_addr[3], 'h001);
        run(1'b0, 'h000, 'h00, 1, dw, rc, gp, sw);
        $display("read back 0x000 after wrap: data=0x%0h", rsp_data);
        chk_eq("wrap_readback", int'(rsp_data), 'h3C);

        // Zero count means 256 words.
        run(1'b1, 'h100, 'h77, 0, dw, rc, gp, sw);
        $display("count0 write 0x100: rsp=%0d done_win=%0d", rc, dw);
        chk_eq("cnt0_rsp_cnt", rc, 256);
        chk_eq("cnt0_done_win", dw, 768);

        // Busy handshake: second command held valid during a 4-word burst.
        present(1'b1, 'h020, 'h11, 4);
        wait_accept(w);
        #1;
        cmd_we = 1'b0; cmd_addr = 'h010; cmd_data = '0; cmd_count = BW'(2);
        track(200, dw, rc, gp, sw);
        $display("busy first burst: done_win=%0d rsp=%0d", dw, rc);
        chk_eq("busy_done_win", dw, 12);
        wait_accept(w);
        #1 cmd_valid = 1'b0;
        $display("busy second accept after %0d window(s)", w);
        chk_eq("busy_second_accept", w, 1);
        @(negedge clk);
        chk_eq("busy_second_stb", int'(wb_stb), 1);
        track(200, dw, rc, gp, sw);
        chk_eq("busy_second_done_win", dw + 1, 6);
        chk_eq("busy_second_data", int'(rsp_data), 'hA5);
        @(negedge clk);

        // Stalled responder.
        ack_gate = 1'b0;
        present(1'b0, 'h010, 'h00, 1);
        wait_accept(w);
        #1 cmd_valid = 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
        track(50, dw, rc, gp, sw);
        $display("timeout abort: done_win=%0d stb=%0d err=%0d", dw, sw, err);
        chk_eq("tmo_done_win", dw, 9);
        chk_eq("tmo_stb_cycles", sw, 8);
        chk_eq("tmo_rsp_cnt", rc, 0);
        chk_eq("tmo_err", int'(err), 1);
        chk_eq("tmo_cyc", int'(wb_cyc), 0);
        chk_eq("tmo_stb", int'(wb_stb), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk_eq("tmo_err_held", int'(err), 1);
        present(1'b0, 'h010, 'h00, 1);
        wait_accept(w);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk_eq("tmo_err_cleared", int'(err), 0);
        repeat (2) @(negedge clk);
`else
        done_seen = 0;
        repeat (1000) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        $display("stall 1000 cycles: cyc=%0d stb=%0d done_seen=%0d", wb_cyc, wb_stb, done_seen);
        chk_eq("stall_done_seen", done_seen, 0);
        chk_eq("stall_cyc", int'(wb_cyc), 1);
        chk_eq("stall_stb", int'(wb_stb), 1);
        chk_eq("stall_err", int'(err), 0);
`endif

        // Asynchronous reset in the middle of STROBE.
        chk_eq("pre_reset_stb", int'(wb_stb), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mid-strobe: cyc=%0d stb=%0d ready=%0d", wb_cyc, wb_stb, cmd_ready);
        chk_eq("arst_cyc", int'(wb_cyc), 0);
        chk_eq("arst_stb", int'(wb_stb), 0);
        chk_eq("arst_ready", int'(cmd_ready), 1);
        chk_eq("arst_done", int'(done), 0);
        chk_eq("arst_rsp_data", int'(rsp_data), 0);
        repeat (2) @(negedge clk);
        chk_eq("arst_done_later", int'(done), 0);
        #1;
        rst_n = 1'b1;
        ack_gate = 1'b1;
        run(1'b0, 'h010, 'h00, 1, dw, rc, gp, sw);
        $display("read after reset 0x010: data=0x%0h done_win=%0d", rsp_data, dw);
        chk_eq("post_rst_data", int'(rsp_data), 'hA5);
        chk_eq("post_rst_done_win", dw, 3);
        chk_eq("model_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute bound on simulated time.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

endmodule : tb_wb_initiator
